// File: rtl/udp_tx_pkg.sv
// Shared definitions for the UDP transmit scheduler: state and requester
// encodings, default parameter values and the payload length rule.
package udp_tx_pkg;

  localparam int DEF_PAYLOAD_BYTES  = 960;
  localparam int DEF_IFG_CYCLES     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;
  localparam int DEF_STARVE_LIMIT   = 4;
  localparam int LEN_W              = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } sched_state_t;

  typedef enum logic {
    REQ_AUDIO = 1'b0,
    REQ_CTRL  = 1'b1
  } req_id_t;

  // A payload is sendable only if it is non-empty and fits the data bus.
  function automatic logic len_ok(input logic [LEN_W-1:0] len,
                                  input logic [31:0] max_bytes);
    return (len != '0) && ({16'd0, len} <= max_bytes);
  endfunction

endpackage

// File: rtl/udp_tx_sched_if.sv
// Transfer bus between the scheduler (master) and the Ethernet UDP stack (slave).
interface udp_tx_sched_if #(
  parameter int PAYLOAD_BYTES = udp_tx_pkg::DEF_PAYLOAD_BYTES
);
  import udp_tx_pkg::*;

  // udp_send_data_valid is a level raised for a granted transfer and held,
  // with udp_send_data/udp_send_data_length stable, until the stack returns
  // a single-cycle udp_send_data_ready completion pulse. Ready seen while no
  // transfer is outstanding carries no meaning and is ignored.
  logic                       udp_send_data_valid;
  logic                       udp_send_data_ready;
  logic [PAYLOAD_BYTES*8-1:0] udp_send_data;
  logic [LEN_W-1:0]           udp_send_data_length;

  modport master (
    output udp_send_data_valid,
    output udp_send_data,
    output udp_send_data_length,
    input  udp_send_data_ready
  );

  modport slave (
    input  udp_send_data_valid,
    input  udp_send_data,
    input  udp_send_data_length,
    output udp_send_data_ready
  );

endinterface

// File: rtl/udp_tx_prio.sv
// Audio-first arbitration with a bounded starvation counter that hands the
// grant to control once audio has won STARVE_LIMIT times in a row.
module udp_tx_prio
  import udp_tx_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    a_req,
  input  logic    c_req,
  input  logic    decide,
  input  logic    grant,
  output req_id_t winner,
  output logic    any_req
);

  localparam int            SW    = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;

  always_comb begin
    any_req = a_req | c_req;
    winner  = REQ_AUDIO;
    if (c_req && (!a_req || starve_cnt == LIMIT)) begin
      winner = REQ_CTRL;
    end
  end

  // A rejected winner leaves the count alone unless control has gone away.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (decide && any_req) begin
      if (!c_req) begin
        starve_cnt <= '0;
      end else if (grant) begin
        if (winner == REQ_CTRL) begin
          starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/udp_tx_sched.sv
// Schedules audio and control payloads onto a single UDP send port:
// arbitration, payload capture, completion timeout, inter-frame gap, statistics.
module udp_tx_sched
  import udp_tx_pkg::*;
#(
  parameter int PAYLOAD_BYTES  = DEF_PAYLOAD_BYTES,
  parameter int IFG_CYCLES     = DEF_IFG_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int STARVE_LIMIT   = DEF_STARVE_LIMIT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_req,
  input  logic [LEN_W-1:0]           a_len,
  input  logic [PAYLOAD_BYTES*8-1:0] a_data,
  output logic                       a_ack,
  output logic                       a_err,
  input  logic                       c_req,
  input  logic [LEN_W-1:0]           c_len,
  input  logic [PAYLOAD_BYTES*8-1:0] c_data,
  output logic                       c_ack,
  output logic                       c_err,
  udp_tx_sched_if.master             udp,
  output logic                       busy,
  output logic [15:0]                sent_cnt_a,
  output logic [15:0]                sent_cnt_c,
  output logic [7:0]                 timeout_cnt,
  output sched_state_t               fsm_state
);

  localparam int            DW        = PAYLOAD_BYTES * 8;
  localparam int            WW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int            GW        = $clog2(IFG_CYCLES + 2);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(IFG_CYCLES - 1);

  sched_state_t     state_q, state_d;
  req_id_t          winner, owner_q;
  logic             any_req;
  logic [LEN_W-1:0] win_len;
  logic             decide, grant, reject, done_ok, done_to;
  logic [WW-1:0]    wait_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [DW-1:0]    data_q;
  logic [LEN_W-1:0] len_q;

  udp_tx_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk     (clk),
    .rst     (rst),
    .a_req   (a_req),
    .c_req   (c_req),
    .decide  (decide),
    .grant   (grant),
    .winner  (winner),
    .any_req (any_req)
  );

  assign win_len = (winner == REQ_CTRL) ? c_len : a_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ready is only consulted in SEND and beats a timeout landing on the same cycle.
  always_comb begin
    state_d = state_q;
    decide  = 1'b0;
    grant   = 1'b0;
    reject  = 1'b0;
    done_ok = 1'b0;
    done_to = 1'b0;
    case (state_q)
      ST_IDLE: begin
        decide = 1'b1;
        if (any_req) begin
          if (len_ok(win_len, 32'(PAYLOAD_BYTES))) begin
            grant   = 1'b1;
            state_d = ST_SEND;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (udp.udp_send_data_ready) begin
          done_ok = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          done_to = 1'b1;
        end
        if (done_ok || done_to) begin
          state_d = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= REQ_AUDIO;
      data_q      <= '0;
      len_q       <= '0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      a_ack       <= 1'b0;
      a_err       <= 1'b0;
      c_ack       <= 1'b0;
      c_err       <= 1'b0;
      sent_cnt_a  <= '0;
      sent_cnt_c  <= '0;
      timeout_cnt <= '0;
    end else begin
      a_ack <= 1'b0;
      a_err <= 1'b0;
      c_ack <= 1'b0;
      c_err <= 1'b0;
      if (grant) begin
        owner_q  <= winner;
        data_q   <= (winner == REQ_CTRL) ? c_data : a_data;
        len_q    <= win_len;
        wait_cnt <= '0;
      end
      if (reject) begin
        if (winner == REQ_CTRL) c_err <= 1'b1;
        else                    a_err <= 1'b1;
      end
      if (state_q == ST_SEND && !done_ok && !done_to) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (done_ok) begin
        if (owner_q == REQ_CTRL) begin
          c_ack      <= 1'b1;
          sent_cnt_c <= sent_cnt_c + 16'd1;
        end else begin
          a_ack      <= 1'b1;
          sent_cnt_a <= sent_cnt_a + 16'd1;
        end
      end
      if (done_to) begin
        if (owner_q == REQ_CTRL) c_err <= 1'b1;
        else                     a_err <= 1'b1;
        if (timeout_cnt != 8'hFF) begin
          timeout_cnt <= timeout_cnt + 8'd1;
        end
      end
      gap_cnt <= (state_q == ST_GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

  assign udp.udp_send_data_valid  = (state_q == ST_SEND);
  assign udp.udp_send_data        = data_q;
  assign udp.udp_send_data_length = len_q;
  assign busy                     = (state_q != ST_IDLE);
  assign fsm_state                = state_q;

  a_ack_err_excl: assert property (@(posedge clk) disable iff (rst) !(a_ack && a_err));
  c_ack_err_excl: assert property (@(posedge clk) disable iff (rst) !(c_ack && c_err));
  send_hold: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_SEND && !done_ok && !done_to) |=>
      (state_q == ST_SEND && $stable(data_q) && $stable(len_q)));

endmodule

// File: tb/tb_udp_tx_sched.sv
// Randomized transaction bench for udp_tx_sched with a transaction-level
// arbitration/outcome model and a grant-order expected queue.
module tb_udp_tx_sched;
  import udp_tx_pkg::*;

  localparam int PB = 960;
  localparam int IFG = 16;
  localparam int TO = 100;
  localparam int SL = 4;
  localparam int DW = PB * 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  logic          a_req, c_req, a_ack, a_err, c_ack, c_err, busy;
  logic [15:0]   a_len, c_len, sent_cnt_a, sent_cnt_c;
  logic [DW-1:0] a_data, c_data;
  logic [7:0]    timeout_cnt;
  sched_state_t  fsm_state;

  udp_tx_sched_if #(.PAYLOAD_BYTES(PB)) udp ();

  udp_tx_sched #(
    .PAYLOAD_BYTES  (PB),
    .IFG_CYCLES     (IFG),
    .TIMEOUT_CYCLES (TO),
    .STARVE_LIMIT   (SL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .a_req       (a_req),
    .a_len       (a_len),
    .a_data      (a_data),
    .a_ack       (a_ack),
    .a_err       (a_err),
    .c_req       (c_req),
    .c_len       (c_len),
    .c_data      (c_data),
    .c_ack       (c_ack),
    .c_err       (c_err),
    .udp         (udp),
    .busy        (busy),
    .sent_cnt_a  (sent_cnt_a),
    .sent_cnt_c  (sent_cnt_c),
    .timeout_cnt (timeout_cnt),
    .fsm_state   (fsm_state)
  );

  // scoreboard and model state
  int         n_cmp = 0;
  int         n_bad = 0;
  int         starve = 0;
  int         m_sent_a = 0;
  int         m_sent_c = 0;
  int         m_to = 0;
  logic [0:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 1 = control wins
  function automatic logic m_winner(input logic ra, input logic rc);
    return rc && (!ra || starve == SL);
  endfunction

  function automatic logic m_len_ok(input logic [15:0] l);
    return int'(l) >= 1 && int'(l) <= PB;
  endfunction

  function automatic logic [DW-1:0] rand_payload();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [15:0] rand_len();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return 16'd0;
    if (r == 1) return 16'($urandom_range(961, 65535));
    return 16'($urandom_range(1, PB));
  endfunction

  // driver: one arbitration round, the resulting transfer and its gap
  task automatic do_xfer(input logic ra, input logic rc, input logic [15:0] la,
                         input logic [15:0] lc, input int delay, input logic perturb,
                         output logic owner_seen);
    int            guard, hi, gap_len;
    logic          w, cur_a, cur_c, granted, stable, quiet, seen;
    logic [DW-1:0] exp_data;
    logic [15:0]   exp_len;
    logic [0:0]    exp_id;
    owner_seen = 1'b0;
    w = 1'b0;
    exp_data = '0;
    exp_len = '0;
    guard = 0;
    while (busy !== 1'b0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("idle_wait", 64'(guard < 300), 64'd1);
    a_req = ra;
    c_req = rc;
    a_len = la;
    c_len = lc;
    a_data = rand_payload();
    c_data = rand_payload();
    udp.udp_send_data_ready = 1'b0;
    cur_a = ra;
    cur_c = rc;
    granted = 1'b0;
    while ((cur_a || cur_c) && !granted) begin
      w = m_winner(cur_a, cur_c);
      @(negedge clk);
      if (!m_len_ok(w ? c_len : a_len)) begin
        chk("rej_err", 64'({a_err, c_err}), 64'(w ? 2'b01 : 2'b10));
        chk("rej_valid", 64'(udp.udp_send_data_valid), 64'd0);
        if (!cur_c) starve = 0;
        if (w) begin
          cur_c = 1'b0;
          c_req = 1'b0;
        end else begin
          cur_a = 1'b0;
          a_req = 1'b0;
        end
      end else begin
        granted = 1'b1;
        if (!cur_c || w) starve = 0;
        else if (starve < SL) starve++;
        exp_q.push_back(w);
        exp_data = w ? c_data : a_data;
        exp_len = w ? c_len : a_len;
        chk("grant_valid", 64'(udp.udp_send_data_valid), 64'd1);
        chk("grant_len", 64'(udp.udp_send_data_length), 64'(exp_len));
        chk("grant_data", 64'(udp.udp_send_data == exp_data), 64'd1);
      end
    end
    if (!granted) begin
      seen = 1'b0;
      repeat (5) begin
        @(negedge clk);
        if (udp.udp_send_data_valid !== 1'b0) seen = 1'b1;
      end
      chk("rej_no_valid", 64'(seen), 64'd0);
      return;
    end
    hi = 0;
    stable = 1'b1;
    quiet = 1'b1;
    while (udp.udp_send_data_valid === 1'b1 && hi < 200) begin
      if (udp.udp_send_data !== exp_data || udp.udp_send_data_length !== exp_len) stable = 1'b0;
      if ({a_ack, a_err, c_ack, c_err} != 4'b0000) quiet = 1'b0;
      udp.udp_send_data_ready = (hi == delay);
      if (perturb && hi == 3) begin
        if (w) begin
          c_data = rand_payload();
          c_req = 1'b0;
        end else begin
          a_data = rand_payload();
          a_req = 1'b0;
        end
      end
      @(negedge clk);
      hi++;
    end
    udp.udp_send_data_ready = 1'b0;
    chk("send_cycles", 64'(hi), 64'(delay < TO ? delay + 1 : TO));
    chk("send_stable", 64'(stable), 64'd1);
    chk("send_quiet", 64'(quiet), 64'd1);
    exp_id = exp_q.pop_front();
    owner_seen = c_ack | c_err;
    chk("owner", 64'(owner_seen), 64'(exp_id));
    if (delay < TO) begin
      if (w) m_sent_c++;
      else m_sent_a++;
      chk("done_ack", 64'({a_ack, a_err, c_ack, c_err}), 64'(w ? 4'b0010 : 4'b1000));
    end else begin
      if (m_to < 255) m_to++;
      chk("done_timeout", 64'({a_ack, a_err, c_ack, c_err}), 64'(w ? 4'b0001 : 4'b0100));
    end
    chk("sent_cnt_a", 64'(sent_cnt_a), 64'(16'(m_sent_a)));
    chk("sent_cnt_c", 64'(sent_cnt_c), 64'(16'(m_sent_c)));
    chk("timeout_cnt", 64'(timeout_cnt), 64'(8'(m_to)));
    gap_len = 0;
    quiet = 1'b1;
    while (fsm_state == ST_GAP && gap_len < 100) begin
      if (gap_len > 0 && {a_ack, a_err, c_ack, c_err} != 4'b0000) quiet = 1'b0;
      if (udp.udp_send_data_valid !== 1'b0 || busy !== 1'b1) quiet = 1'b0;
      udp.udp_send_data_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      gap_len++;
    end
    udp.udp_send_data_ready = 1'b0;
    chk("gap_len", 64'(gap_len), 64'(IFG));
    chk("gap_quiet", 64'(quiet), 64'd1);
  endtask

  initial begin
    logic        own, ra, rc, pert;
    logic [9:0]  order;
    int          dly, guard;
    rst = 1'b1;
    a_req = 1'b0;
    c_req = 1'b0;
    a_len = '0;
    c_len = '0;
    a_data = '0;
    c_data = '0;
    udp.udp_send_data_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(udp.udp_send_data_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pulses", 64'({a_ack, a_err, c_ack, c_err}), 64'd0);
    chk("rst_counters", 64'({sent_cnt_a, sent_cnt_c, timeout_cnt}), 64'd0);
    chk("rst_len", 64'(udp.udp_send_data_length), 64'd0);
    chk("rst_data", 64'(udp.udp_send_data == '0), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // full-length audio, ready ten cycles after valid
    do_xfer(1'b1, 1'b0, 16'd960, 16'd0, 10, 1'b0, own);

    // control with zero and oversize lengths
    do_xfer(1'b0, 1'b1, 16'd0, 16'd0, 5, 1'b0, own);
    do_xfer(1'b0, 1'b1, 16'd0, 16'd961, 5, 1'b0, own);
    chk("rej_sent_c", 64'(sent_cnt_c), 64'd0);

    // both requesters held: starvation limit forces every fifth grant to control
    order = '0;
    for (int i = 0; i < 10; i++) begin
      do_xfer(1'b1, 1'b1, 16'($urandom_range(1, PB)), 16'($urandom_range(1, PB)), 5, 1'b0, own);
      order[9-i] = own;
    end
    a_req = 1'b0;
    c_req = 1'b0;
    chk("grant_order", 64'(order), 64'(10'b0000100001));

    // timeout, then ready on the last wait cycle
    do_xfer(1'b1, 1'b0, 16'd500, 16'd0, 1000, 1'b0, own);
    do_xfer(1'b1, 1'b0, 16'd500, 16'd0, TO - 1, 1'b0, own);

    // requester changes data and drops req mid-transfer
    do_xfer(1'b1, 1'b0, 16'd321, 16'd0, 8, 1'b1, own);

    for (int t = 0; t < 40; t++) begin
      ra = 1'($urandom_range(0, 1));
      rc = ra ? 1'($urandom_range(0, 1)) : 1'b1;
      dly = ($urandom_range(0, 9) < 2) ? int'($urandom_range(95, 105)) : int'($urandom_range(0, 30));
      pert = ($urandom_range(0, 3) == 0);
      do_xfer(ra, rc, rand_len(), rand_len(), dly, pert, own);
    end
    a_req = 1'b0;
    c_req = 1'b0;
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

    // reset in the middle of a transfer
    guard = 0;
    while (busy !== 1'b0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    a_req = 1'b1;
    a_len = 16'd100;
    a_data = rand_payload();
    @(negedge clk);
    chk("rst_mid_valid_before", 64'(udp.udp_send_data_valid), 64'd1);
    a_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", 64'(udp.udp_send_data_valid), 64'd0);
    chk("rst_mid_pulses", 64'({a_ack, a_err, c_ack, c_err}), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_counters", 64'({sent_cnt_a, sent_cnt_c, timeout_cnt}), 64'd0);
    chk("rst_mid_len", 64'(udp.udp_send_data_length), 64'd0);
    rst = 1'b0;
    starve = 0;
    m_sent_a = 0;
    m_sent_c = 0;
    m_to = 0;
    @(negedge clk);
    chk("post_rst_pulses", 64'({a_ack, a_err, c_ack, c_err}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
